multicycle_mips_core: RTL and testbench

//  Multi-cycle MIPS-I subset core; successor to the single-cycle CPU.

---
 rtl/multicycle_mips_core.sv | 228 ++++++++++++++++++++++
 tb/tb_multicycle_mips_core.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_mips_core.sv
// Multi-cycle MIPS-I subset core with one shared ALU and one unified memory
// port using a req/ack handshake.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   mem_req/mem_we       memory request (held until mem_ack) / write select
//   mem_addr/mem_wdata   word-aligned byte address / store data
//   mem_rdata/mem_ack    read data / request completion
//   retire               pulse in the final cycle of each completed instruction
//   halted/trap_code     sticky halt flag / trap cause (1 illegal, 2 misaligned)
//   pc_o                 current program counter
module multicycle_mips_core #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter bit          ALIGN_CHECK = 1'b1,
    parameter bit          WB_R0_GUARD = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        retire,
    output logic        halted,
    output logic [1:0]  trap_code,
    output logic [31:0] pc_o
);
    localparam int unsigned XLEN = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_BEQ  = 6'h04,
                           OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_ANDI = 6'h0C,
                           OP_ORI   = 6'h0D, OP_LUI  = 6'h0F, OP_LW   = 6'h23,
                           OP_SW    = 6'h2B;
    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_ADD = 6'h20,
                           F_SUB = 6'h22, F_AND = 6'h24, F_OR  = 6'h25,
                           F_SLT = 6'h2A;
    localparam logic [1:0] TRAP_ILLEGAL = 2'd1, TRAP_MISALIGN = 2'd2;

    typedef enum logic [2:0] {
        S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t            state, state_nx;
    logic [XLEN-1:0]   pc, pc_nx, ir, ir_nx, a, a_nx, b, b_nx;
    logic [XLEN-1:0]   alu_out, alu_nx, mdr, mdr_nx, alu_res;
    logic [1:0]        trap_nx;
    logic [XLEN-1:0]   gpr [32];
    logic              wb_en;
    logic [4:0]        wb_idx;
    logic [XLEN-1:0]   wb_data;

    // Instruction fields
    logic [5:0]      op, funct;
    logic [4:0]      rs, rt, rd, shamt;
    logic [15:0]     imm;
    logic [XLEN-1:0] simm, zimm;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign shamt = ir[10:6];
    assign funct = ir[5:0];
    assign imm   = ir[15:0];
    assign simm  = {{16{imm[15]}}, imm};
    assign zimm  = {16'h0000, imm};

    assign halted = (state == S_HALT);
    assign pc_o   = pc;

    function automatic logic is_legal(input logic [5:0] o, input logic [5:0] f);
        if (o == OP_RTYPE)
            return (f == F_ADD) || (f == F_SUB) || (f == F_AND) || (f == F_OR) ||
                   (f == F_SLT) || (f == F_SLL) || (f == F_SRL);
        return (o == OP_ADDI) || (o == OP_ANDI) || (o == OP_ORI) || (o == OP_LUI) ||
               (o == OP_LW)   || (o == OP_SW)   || (o == OP_BEQ) || (o == OP_BNE) ||
               (o == OP_J);
    endfunction

    // Shared ALU; branches use subtraction and test for zero
    always_comb begin
        alu_res = '0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_ADD:   alu_res = a + b;
                    F_SUB:   alu_res = a - b;
                    F_AND:   alu_res = a & b;
                    F_OR:    alu_res = a | b;
                    F_SLT:   alu_res = {31'b0, ($signed(a) < $signed(b))};
                    F_SLL:   alu_res = b << shamt;
                    F_SRL:   alu_res = b >> shamt;
                    default: alu_res = '0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: alu_res = a + simm;
            OP_ANDI:               alu_res = a & zimm;
            OP_ORI:                alu_res = a | zimm;
            OP_LUI:                alu_res = {imm, 16'h0000};
            OP_BEQ, OP_BNE:        alu_res = a - b;
            default:               alu_res = '0;
        endcase
    end

    // Next-state, datapath updates and memory/retire outputs
    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        ir_nx     = ir;
        a_nx      = a;
        b_nx      = b;
        alu_nx    = alu_out;
        mdr_nx    = mdr;
        trap_nx   = trap_code;
        wb_en     = 1'b0;
        wb_idx    = (op == OP_RTYPE) ? rd : rt;
        wb_data   = (op == OP_LW) ? mdr : alu_out;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        retire    = 1'b0;
        case (state)
            S_RST: state_nx = S_FETCH;
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = {pc[31:2], 2'b00};
                if (mem_ack) begin
                    ir_nx    = mem_rdata;
                    pc_nx    = pc + 32'd4;
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                a_nx = gpr[rs];
                b_nx = gpr[rt];
                if (!is_legal(op, funct)) begin
                    trap_nx  = TRAP_ILLEGAL;
                    state_nx = S_HALT;
                end else begin
                    state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_nx = alu_res;
                case (op)
                    OP_BEQ, OP_BNE: begin
                        // pc already points past the branch
                        if ((op == OP_BEQ) == (alu_res == '0))
                            pc_nx = pc + (simm << 2);
                        retire   = 1'b1;
                        state_nx = S_FETCH;
                    end
                    OP_J: begin
                        pc_nx    = {pc[31:28], ir[25:0], 2'b00};
                        retire   = 1'b1;
                        state_nx = S_FETCH;
                    end
                    OP_LW, OP_SW: begin
                        if (ALIGN_CHECK && (alu_res[1:0] != 2'b00)) begin
                            trap_nx  = TRAP_MISALIGN;
                            state_nx = S_HALT;
                        end else begin
                            state_nx = S_MEM;
                        end
                    end
                    default: state_nx = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_we    = (op == OP_SW);
                mem_addr  = {alu_out[31:2], 2'b00};
                mem_wdata = b;
                if (mem_ack) begin
                    if (op == OP_SW) begin
                        retire   = 1'b1;
                        state_nx = S_FETCH;
                    end else begin
                        mdr_nx   = mem_rdata;
                        state_nx = S_WB;
                    end
                end
            end
            S_WB: begin
                wb_en    = !(WB_R0_GUARD && (wb_idx == 5'd0));
                retire   = 1'b1;
                state_nx = S_FETCH;
            end
            S_HALT:  state_nx = S_HALT;
            default: state_nx = S_RST;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_RST;
            pc        <= RESET_PC;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            alu_out   <= '0;
            mdr       <= '0;
            trap_code <= '0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            ir        <= ir_nx;
            a         <= a_nx;
            b         <= b_nx;
            alu_out   <= alu_nx;
            mdr       <= mdr_nx;
            trap_code <= trap_nx;
        end
    end

    // Register file
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) gpr[i] <= '0;
        end else if (wb_en) begin
            gpr[wb_idx] <= wb_data;
        end
    end

endmodule

// File: tb/tb_multicycle_mips_core.sv
// Self-checking bench for multicycle_mips_core: an instruction-level model
// predicts every memory transaction, retire latency and halt cause.
module tb_multicycle_mips_core;
    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] ILL = 32'hFC00_0000;

    logic        clk;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, retire, halted;
    logic [31:0] mem_addr, mem_wdata, pc_o;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [1:0]  trap_code;

    multicycle_mips_core #(.RESET_PC(RPC), .ALIGN_CHECK(1'b1), .WB_R0_GUARD(1'b1)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .retire(retire), .halted(halted),
        .trap_code(trap_code), .pc_o(pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 transaction, 1 retire, 2 halt
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        fetch;
        int          lat;
        logic [1:0]  trap;
    } ev_t;

    logic [31:0] img   [1024];
    logic [31:0] mem   [1024];
    logic [31:0] m_mem [1024];
    logic [31:0] m_reg [32];
    ev_t         evq[$];
    logic [31:0] fetch_log[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          ack_mode = 0;
    bit          chk_en = 0;
    bit          model_open = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got event with nothing expected (t=%0t)", name, $time);
    endtask

    function automatic ev_t mk_ev(input int kind, input logic [31:0] addr, input logic we,
                                  input logic [31:0] wd, input logic fetch, input int lat,
                                  input logic [1:0] trap);
        ev_t e;
        e.kind = kind; e.addr = addr; e.we = we; e.wdata = wd;
        e.fetch = fetch; e.lat = lat; e.trap = trap;
        return e;
    endfunction

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] target);
        return {6'h02, target[27:2]};
    endfunction

    // Instruction-set model: executes the image and queues the expected events
    task automatic iss_run(input int max_steps, output bit ended_halt);
        logic [31:0] pc, npc, instr, a, b, simm, res, ea;
        logic [5:0]  op, fn;
        logic [4:0]  dst;
        bit          legal, has_wr;
        int          lat;
        logic [1:0]  trap;
        evq.delete();
        fetch_log.delete();
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        for (int i = 0; i < 1024; i++) m_mem[i] = img[i];
        pc = RPC;
        ended_halt = 0;
        for (int s = 0; s < max_steps && !ended_halt; s++) begin
            instr = m_mem[pc[11:2]];
            evq.push_back(mk_ev(0, pc, 1'b0, '0, 1'b1, 0, 2'd0));
            fetch_log.push_back(pc);
            npc  = pc + 32'd4;
            op   = instr[31:26];
            fn   = instr[5:0];
            a    = m_reg[instr[25:21]];
            b    = m_reg[instr[20:16]];
            simm = {{16{instr[15]}}, instr[15:0]};
            legal = 1; has_wr = 0; lat = 4; trap = 2'd0; res = '0; dst = '0;
            case (op)
                6'h00: begin
                    dst = instr[15:11]; has_wr = 1;
                    case (fn)
                        6'h20:   res = a + b;
                        6'h22:   res = a - b;
                        6'h24:   res = a & b;
                        6'h25:   res = a | b;
                        6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        6'h00:   res = b << instr[10:6];
                        6'h02:   res = b >> instr[10:6];
                        default: legal = 0;
                    endcase
                end
                6'h08: begin res = a + simm; dst = instr[20:16]; has_wr = 1; end
                6'h0C: begin res = a & {16'h0, instr[15:0]}; dst = instr[20:16]; has_wr = 1; end
                6'h0D: begin res = a | {16'h0, instr[15:0]}; dst = instr[20:16]; has_wr = 1; end
                6'h0F: begin res = {instr[15:0], 16'h0}; dst = instr[20:16]; has_wr = 1; end
                6'h23, 6'h2B: begin
                    ea = a + simm;
                    if (ea[1:0] != 2'b00) begin
                        trap = 2'd2;
                    end else if (op == 6'h23) begin
                        evq.push_back(mk_ev(0, ea, 1'b0, '0, 1'b0, 0, 2'd0));
                        res = m_mem[ea[11:2]]; dst = instr[20:16]; has_wr = 1; lat = 5;
                    end else begin
                        evq.push_back(mk_ev(0, ea, 1'b1, b, 1'b0, 0, 2'd0));
                        m_mem[ea[11:2]] = b;
                    end
                end
                6'h04, 6'h05: begin
                    lat = 3;
                    if ((a == b) == (op == 6'h04)) npc = npc + (simm << 2);
                end
                6'h02: begin lat = 3; npc = {npc[31:28], instr[25:0], 2'b00}; end
                default: legal = 0;
            endcase
            if (!legal) trap = 2'd1;
            if (trap != 2'd0) begin
                evq.push_back(mk_ev(2, '0, 1'b0, '0, 1'b0, 0, trap));
                ended_halt = 1;
            end else begin
                if (has_wr && dst != 5'd0) m_reg[dst] = res;
                evq.push_back(mk_ev(1, '0, 1'b0, '0, 1'b0, lat, 2'd0));
                pc = npc;
            end
        end
    endtask

    // Memory responder plus per-cycle comparison against the model's events
    int          cyc_cnt, wait_cnt, wcnt;
    bit          started, halt_seen, prev_wait;
    logic [31:0] prev_addr, prev_wdata;
    logic        prev_we;

    task automatic check_cycle();
        ev_t e;
        if (mem_req) started = 1;
        if (!started) return;
        cyc_cnt++;
        if (mem_req && !mem_ack) wait_cnt++;
        if (prev_wait && mem_req) begin
            check32("hold_addr", mem_addr, prev_addr);
            check32("hold_we", 32'(mem_we), 32'(prev_we));
            check32("hold_wdata", mem_wdata, prev_wdata);
        end
        prev_wait  = mem_req && !mem_ack;
        prev_addr  = mem_addr;
        prev_we    = mem_we;
        prev_wdata = mem_wdata;
        if (halt_seen) begin
            check32("halt_quiet", {30'b0, mem_req, retire}, 32'd0);
            return;
        end
        if (mem_req && mem_ack) begin
            if (evq.size() == 0) begin
                if (!model_open) fail_now("extra_txn");
            end else begin
                e = evq.pop_front();
                check32("txn_kind", 32'(e.kind), 32'd0);
                check32("txn_addr", mem_addr, e.addr);
                check32("txn_we", 32'(mem_we), 32'(e.we));
                if (e.we) check32("txn_wdata", mem_wdata, e.wdata);
                if (e.fetch) check32("fetch_pc", pc_o, e.addr);
            end
        end
        if (retire) begin
            if (evq.size() == 0) begin
                if (!model_open) fail_now("extra_retire");
            end else begin
                e = evq.pop_front();
                check32("retire_kind", 32'(e.kind), 32'd1);
                check32("retire_latency", 32'(cyc_cnt), 32'(e.lat + wait_cnt));
            end
            cyc_cnt = 0;
            wait_cnt = 0;
        end
        if (halted) begin
            halt_seen = 1;
            if (evq.size() == 0) fail_now("extra_halt");
            else begin
                e = evq.pop_front();
                check32("halt_kind", 32'(e.kind), 32'd2);
                check32("trap_code", 32'(trap_code), 32'(e.trap));
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mem_ack = 1'b0;
            started = 0; halt_seen = 0; prev_wait = 0;
            cyc_cnt = 0; wait_cnt = 0; wcnt = 0;
            for (int i = 0; i < 1024; i++) mem[i] = img[i];
        end else begin
            if (mem_req) begin
                case (ack_mode)
                    0: mem_ack = 1'b1;
                    1: mem_ack = ($urandom_range(0, 1) == 1);
                    2: begin
                        if (wcnt == 3) begin mem_ack = 1'b1; wcnt = 0; end
                        else begin mem_ack = 1'b0; wcnt++; end
                    end
                    4: mem_ack = !mem_we;
                    default: mem_ack = 1'b0;
                endcase
                mem_rdata = mem[mem_addr[11:2]];
            end else begin
                mem_ack   = (ack_mode == 1) && ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
            #1;
            if (chk_en) check_cycle();
            if (mem_req && mem_ack && mem_we) mem[mem_addr[11:2]] = mem_wdata;
        end
    end

    task automatic do_reset();
        chk_en = 0;
        @(negedge clk); #2 rst = 1'b1;
        @(negedge clk); #2;
        check32("rst_req", {31'b0, mem_req}, 32'd0);
        check32("rst_we", {31'b0, mem_we}, 32'd0);
        check32("rst_addr", mem_addr, 32'd0);
        check32("rst_wdata", mem_wdata, 32'd0);
        check32("rst_flags", {29'b0, retire, halted, 1'b0}, 32'd0);
        check32("rst_trap", {30'b0, trap_code}, 32'd0);
        check32("rst_pc", pc_o, RPC);
        rst = 1'b0;
        chk_en = 1;
        @(negedge clk); #2;
        check32("first_fetch_req", {31'b0, mem_req}, 32'd1);
        check32("first_fetch_addr", mem_addr, RPC);
    endtask

    task automatic run_prog(input int mode, input int max_steps, input int budget);
        bit ended;
        int c;
        iss_run(max_steps, ended);
        model_open = !ended;
        ack_mode = mode;
        do_reset();
        c = 0;
        while (evq.size() != 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (evq.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL run_timeout: %0d events left after %0d cycles", evq.size(), budget);
        end
        repeat (4) @(negedge clk);
        chk_en = 0;
    endtask

    task automatic fill_img();
        for (int i = 0; i < 1024; i++) img[i] = ILL;
    endtask

    task automatic gen_random();
        logic [5:0]  fns [7];
        logic [4:0]  r1, r2, r3, sh;
        int          k, sel;
        logic [31:0] w, tgt;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};
        fill_img();
        for (int i = 512; i < 1024; i++) img[i] = $urandom;
        for (k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 13);
            r1 = 5'($urandom_range(0, 7));
            r2 = 5'($urandom_range(0, 7));
            r3 = 5'($urandom_range(0, 7));
            if (sel <= 6) begin
                sh = (sel >= 5) ? 5'($urandom_range(0, 31)) : 5'd0;
                w = enc_r(fns[sel], r1, r2, r3, sh);
            end else if (sel == 7) w = enc_i(6'h08, r1, r2, 16'($urandom));
            else if (sel == 8)  w = enc_i(6'h0C, r1, r2, 16'($urandom));
            else if (sel == 9)  w = enc_i(6'h0D, r1, r2, 16'($urandom));
            else if (sel == 10) w = enc_i(6'h0F, r1, r2, 16'($urandom));
            else if (sel == 11) w = enc_i(6'h23, 5'd0, r2, 16'(32'h800 + 4 * $urandom_range(0, 63)));
            else if (sel == 12) w = enc_i(6'h2B, 5'd0, r2, 16'(32'h800 + 4 * $urandom_range(0, 63)));
            else begin
                case ($urandom_range(0, 2))
                    0: w = enc_i(6'h04, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                                 16'($urandom_range(0, 3)));
                    1: w = enc_i(6'h05, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                                 16'($urandom_range(0, 3)));
                    default: begin
                        tgt = RPC + 32'(4 * (k + 1 + $urandom_range(0, 3)));
                        w = enc_j(tgt);
                    end
                endcase
            end
            img[64 + k] = w;
        end
    endtask

    localparam int P = 64;   // image index of RPC

    initial begin
        logic [31:0] exp_fetch [8];
        bit dummy;
        int c;
        fill_img();
        repeat (2) @(negedge clk);

        // Arithmetic, load/store and $0 write guard
        fill_img();
        img[4] = 32'hDEAD_BEEF;
        img[P + 0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        img[P + 1]  = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
        img[P + 2]  = enc_r(6'h20, 5'd1, 5'd2, 5'd3, 5'd0);
        img[P + 3]  = enc_r(6'h2A, 5'd2, 5'd1, 5'd4, 5'd0);
        img[P + 4]  = enc_i(6'h2B, 5'd0, 5'd3, 16'd8);
        img[P + 5]  = enc_i(6'h23, 5'd0, 5'd5, 16'd8);
        img[P + 6]  = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
        img[P + 7]  = enc_r(6'h20, 5'd0, 5'd0, 5'd6, 5'd0);
        img[P + 8]  = enc_i(6'h2B, 5'd0, 5'd5, 16'd12);
        img[P + 9]  = enc_i(6'h2B, 5'd0, 5'd6, 16'd16);
        img[P + 10] = enc_i(6'h2B, 5'd0, 5'd4, 16'd20);
        for (int mode = 0; mode < 3; mode += 2) begin
            run_prog(mode, 50, 400);
            check32("model_r3", m_reg[3], 32'd2);
            check32("model_r4", m_reg[4], 32'd1);
            check32("model_r5", m_reg[5], 32'd2);
            check32("model_r6", m_reg[6], 32'd0);
            check32("mem_8", mem[2], 32'd2);
            check32("mem_12", mem[3], 32'd2);
            check32("mem_16", mem[4], 32'd0);
            check32("mem_20", mem[5], 32'd1);
            check32("end_trap", {30'b0, trap_code}, 32'd1);
            check32("end_halted", {31'b0, halted}, 32'd1);
        end

        // Branch and jump targets
        fill_img();
        img[P]  = enc_j(32'h20);
        img[8]  = enc_i(6'h05, 5'd0, 5'd0, 16'd5);
        img[9]  = enc_j(32'h40);
        img[16] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
        img[17] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
        exp_fetch = '{32'h100, 32'h20, 32'h24, 32'h40, 32'h44, 32'h44, 32'h44, 32'h44};
        run_prog(0, 8, 200);
        for (int i = 0; i < 8; i++) check32("model_fetch_seq", fetch_log[i], exp_fetch[i]);
        run_prog(1, 8, 400);

        // Illegal funct halts with trap 1
        fill_img();
        img[P]     = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
        img[P + 1] = enc_r(6'h21, 5'd1, 5'd1, 5'd2, 5'd0);
        run_prog(1, 10, 200);
        check32("illegal_trap", {30'b0, trap_code}, 32'd1);
        check32("illegal_halted", {31'b0, halted}, 32'd1);

        // Misaligned load halts with trap 2 and no data access
        fill_img();
        img[P] = enc_i(6'h23, 5'd0, 5'd2, 16'd6);
        run_prog(0, 10, 200);
        check32("misalign_trap", {30'b0, trap_code}, 32'd2);
        check32("misalign_halted", {31'b0, halted}, 32'd1);

        // Reset during a stalled store aborts at once
        fill_img();
        img[P] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0800);
        evq.delete();
        model_open = 1;
        ack_mode = 4;
        do_reset();
        chk_en = 0;
        c = 0;
        while (!(mem_req && mem_we) && c < 20) begin
            @(negedge clk); #2;
            c++;
        end
        check32("reach_mem_wait", {31'b0, mem_req && mem_we}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check32("abort_req", {31'b0, mem_req}, 32'd0);
        check32("abort_pc", pc_o, RPC);
        @(negedge clk); #2 rst = 1'b0;

        // Random programs with random memory stalls
        for (int r = 0; r < 8; r++) begin
            gen_random();
            run_prog(1, 300, 6000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish expected finish before 3ms");
        $fatal(1, "watchdog");
    end

endmodule
